// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/serial_adder_fa_bit.sv
// One-bit full adder cell shared by every bit position of the serial datapath.
module fa_bit (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic ab_x;
    logic ab_a;
    logic xc_a;

    // Gate-level sum and majority carry
    assign ab_x = a ^ b;
    assign ab_a = a & b;
    assign xc_a = ab_x & ci;
    assign s    = ab_x ^ ci;
    assign co   = ab_a | xc_a;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: LSB-first through one full-adder cell, valid/ready in and out.
module serial_adder #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         ovf
);

    import serial_adder_pkg::*;

    localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

    state_t        state_q;
    state_t        state_d;
    logic [W-1:0]  a_sh;
    logic [W-1:0]  b_sh;
    logic          carry;
    logic [CW-1:0] cnt;
    logic          load_c;
    logic          step_c;
    logic          last_c;
    logic          fa_s;
    logic          fa_co;

    fa_bit u_fa (
        .a  (a_sh[0]),
        .b  (b_sh[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    // Next-state and datapath control
    always_comb begin
        state_d = state_q;
        load_c  = 1'b0;
        step_c  = 1'b0;
        last_c  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready) begin
                    load_c  = 1'b1;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                step_c = 1'b1;
                if (cnt == CW'(W - 1)) begin
                    last_c  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Registered handshake flags follow the upcoming state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            in_ready  <= (state_d == ST_IDLE);
            out_valid <= (state_d == ST_DONE);
        end
    end

    // Operand shifters, carry flop, bit counter and result capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh  <= '0;
            b_sh  <= '0;
            sum   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else if (load_c) begin
            // Subtraction is A + ~B + 1; cin is ignored in that mode
            a_sh  <= a;
            b_sh  <= (sub == MODE_SUB) ? ~b : b;
            carry <= (sub == MODE_SUB) ? 1'b1 : cin;
            cnt   <= '0;
        end else if (step_c) begin
            a_sh  <= a_sh >> 1;
            b_sh  <= b_sh >> 1;
            sum   <= (sum >> 1) | (W'(fa_s) << (W - 1));
            carry <= fa_co;
            cnt   <= cnt + CW'(1);
            if (last_c) begin
                // Carry into the MSB xor carry out of it flags signed overflow
                cout <= fa_co;
                ovf  <= carry ^ fa_co;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder (W=8 and W=1 instances).
`timescale 1ns/1ps
module tb_serial_adder;

    logic       clk;
    logic       rst_n;

    logic       in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
    logic [7:0] a, b, sum;

    logic       iv1, ir1, cin1, sub1, ov1, or1, cout1, ovf1;
    logic [0:0] a1, b1, sum1;

    int checks;
    int errors;

    serial_adder #(.W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
    );

    serial_adder #(.W(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1),
        .a(a1), .b(b1), .cin(cin1), .sub(sub1), .out_valid(ov1),
        .out_ready(or1), .sum(sum1), .cout(cout1), .ovf(ovf1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present an operation, wait for accept, then count edges until out_valid (-1 on timeout)
    task automatic run8(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                        input logic ts, output int lat);
        a = ta; b = tb; cin = tc; sub = ts; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) lat = -1;
    endtask

    task automatic release8();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        checks++; if ({sum, cout, ovf} !== 10'h0) begin errors++; $display("FAIL reset_outputs got %h exp 000", {sum, cout, ovf}); end
        checks++; if ({ir1, ov1, sum1, cout1, ovf1} !== 5'b10000) begin errors++; $display("FAIL reset_w1 got %b exp 10000", {ir1, ov1, sum1, cout1, ovf1}); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_add_basic();
        int lat;
        run8(8'h5A, 8'h3C, 1'b0, 1'b0, lat);
        checks++; if (lat !== 8) begin errors++; $display("FAIL add_latency got %0d exp 8", lat); end
        checks++; if (sum !== 8'h96) begin errors++; $display("FAIL add_sum got %h exp 96", sum); end
        checks++; if (cout !== 1'b0) begin errors++; $display("FAIL add_cout got %b exp 0", cout); end
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL add_ovf got %b exp 1", ovf); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL done_in_ready got %b exp 0", in_ready); end
        release8();
        checks++; if ({out_valid, in_ready} !== 2'b01) begin errors++; $display("FAIL transfer_idle got %b exp 01", {out_valid, in_ready}); end
    endtask

    task automatic test_add_carry();
        int lat;
        run8(8'hFF, 8'h01, 1'b0, 1'b0, lat);
        checks++; if ({lat == 8, sum, cout, ovf} !== {1'b1, 8'h00, 1'b1, 1'b0}) begin errors++;
            $display("FAIL carry_ff01 got lat=%0d sum=%h cout=%b ovf=%b exp lat=8 sum=00 cout=1 ovf=0", lat, sum, cout, ovf); end
        release8();
        run8(8'hFF, 8'h00, 1'b1, 1'b0, lat);
        checks++; if ({lat == 8, sum, cout, ovf} !== {1'b1, 8'h00, 1'b1, 1'b0}) begin errors++;
            $display("FAIL carry_cin got lat=%0d sum=%h cout=%b ovf=%b exp lat=8 sum=00 cout=1 ovf=0", lat, sum, cout, ovf); end
        release8();
    endtask

    task automatic test_sub();
        int lat;
        run8(8'h10, 8'h20, 1'b0, 1'b1, lat);
        checks++; if ({lat == 8, sum, cout, ovf} !== {1'b1, 8'hF0, 1'b0, 1'b0}) begin errors++;
            $display("FAIL sub_borrow got lat=%0d sum=%h cout=%b ovf=%b exp lat=8 sum=f0 cout=0 ovf=0", lat, sum, cout, ovf); end
        release8();
        // cin driven high to show it has no effect in subtract mode
        run8(8'h80, 8'h01, 1'b1, 1'b1, lat);
        checks++; if ({lat == 8, sum, cout, ovf} !== {1'b1, 8'h7F, 1'b1, 1'b1}) begin errors++;
            $display("FAIL sub_ovf got lat=%0d sum=%h cout=%b ovf=%b exp lat=8 sum=7f cout=1 ovf=1", lat, sum, cout, ovf); end
        release8();
    endtask

    task automatic test_back_pressure();
        int lat;
        int n;
        run8(8'h70, 8'h70, 1'b0, 1'b0, lat);
        checks++; if (lat !== 8) begin errors++; $display("FAIL bp_latency got %0d exp 8", lat); end
        for (int i = 0; i < 5; i++) begin
            a = 8'(i * 37 + 5); b = 8'(i * 91 + 3); in_valid = (i % 2 == 0); sub = (i % 3 == 0);
            @(posedge clk); #1;
            checks++; if ({out_valid, in_ready, sum, cout, ovf} !== {1'b1, 1'b0, 8'hE0, 1'b0, 1'b1}) begin errors++;
                $display("FAIL bp_hold cyc=%0d got ov=%b ir=%b sum=%h cout=%b ovf=%b exp ov=1 ir=0 sum=e0 cout=0 ovf=1",
                         i, out_valid, in_ready, sum, cout, ovf); end
        end
        // Transfer with in_valid high: only the transfer happens this edge
        a = 8'h01; b = 8'h02; cin = 1'b0; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++; if ({out_valid, in_ready} !== 2'b01) begin errors++; $display("FAIL bp_transfer got %b exp 01", {out_valid, in_ready}); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_accept got in_ready=%b exp 0", in_ready); end
        // Operands changed after accept must not affect the result
        a = 8'hFF; b = 8'hFF; cin = 1'b1; sub = 1'b1;
        n = 0;
        while (!out_valid && n < 40) begin @(posedge clk); #1; n++; end
        checks++; if ({n == 8, sum, cout, ovf} !== {1'b1, 8'h03, 1'b0, 1'b0}) begin errors++;
            $display("FAIL bp_capture got lat=%0d sum=%h cout=%b ovf=%b exp lat=8 sum=03 cout=0 ovf=0", n, sum, cout, ovf); end
        release8();
    endtask

    task automatic test_reset_mid();
        int lat;
        a = 8'hAA; b = 8'h55; cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({in_ready, out_valid, sum, cout, ovf} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin errors++;
            $display("FAIL midreset got ir=%b ov=%b sum=%h cout=%b ovf=%b exp ir=1 ov=0 sum=00 cout=0 ovf=0",
                     in_ready, out_valid, sum, cout, ovf); end
        @(negedge clk); rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        checks++; if ({in_ready, out_valid} !== 2'b10) begin errors++; $display("FAIL midreset_abandon got %b exp 10", {in_ready, out_valid}); end
        run8(8'h01, 8'h01, 1'b0, 1'b0, lat);
        checks++; if ({lat == 8, sum, cout, ovf} !== {1'b1, 8'h02, 1'b0, 1'b0}) begin errors++;
            $display("FAIL after_reset got lat=%0d sum=%h cout=%b ovf=%b exp lat=8 sum=02 cout=0 ovf=0", lat, sum, cout, ovf); end
        release8();
    endtask

    task automatic test_w1();
        logic [2:0] v;
        logic       es;
        logic       ec;
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            a1 = v[2]; b1 = v[1]; cin1 = v[0]; sub1 = 1'b0; iv1 = 1'b1;
            es = v[2] ^ v[1] ^ v[0];
            ec = (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]);
            @(posedge clk); #1;
            iv1 = 1'b0;
            checks++; if ({ir1, ov1} !== 2'b00) begin errors++; $display("FAIL w1_busy abc=%b got %b exp 00", v, {ir1, ov1}); end
            @(posedge clk); #1;
            checks++; if ({ov1, sum1, cout1, ovf1} !== {1'b1, es, ec, v[0] ^ ec}) begin errors++;
                $display("FAIL w1_result abc=%b got ov=%b s=%b c=%b o=%b exp ov=1 s=%b c=%b o=%b",
                         v, ov1, sum1, cout1, ovf1, es, ec, v[0] ^ ec); end
            or1 = 1'b1;
            @(posedge clk); #1;
            or1 = 1'b0;
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        iv1 = 1'b0; or1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0; sub1 = 1'b0;
        test_reset();
        test_add_basic();
        test_add_carry();
        test_sub();
        test_back_pressure();
        test_reset_mid();
        test_w1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
